fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, 16'h0000, fetch address after reset.
REQ-002 Parameter DEPTH, 2, queue entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  decode cannot accept the head entry this cycle.
REQ-006 redirect  input  1  taken branch or jump resolved in memory-access stage.
REQ-007 redirect_pc  input  16  new fetch address, sampled when redirect=1.
REQ-008 halt  input  1  HALT decoded; fetch stops permanently until reset.
REQ-009 mem_ready  input  1  instruction memory returns data this cycle.
REQ-010 mem_rdata  input  16  instruction word, valid when mem_ready=1.
REQ-011 mem_err  input  1  memory fault, valid when mem_ready=1.
REQ-012 mem_req  output  1  fetch request outstanding.
REQ-013 mem_addr  output  16  fetch address.
REQ-014 instr  output  16  head instruction.
REQ-015 pc_inc2  output  16  head instruction address + 2.
REQ-016 valid  output  1  instr and pc_inc2 are meaningful.
REQ-017 err  output  1  sticky error flag, ORed into the processor err.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DROP and HALTED.
REQ-019 IDLE -> REQ when halt=0, redirect=0 and count + 0 < DEPTH; mem_req is asserted in the following cycle with mem_addr = fetch_pc.
REQ-020 In REQ and DROP, mem_req and mem_addr SHALL stay stable until the cycle mem_ready=1. A request is never withdrawn; only one is outstanding at a time.
REQ-021 REQ with mem_ready=1 and no redirect: enqueue {mem_rdata, fetch_pc+2}, set fetch_pc += 2 (16-bit wrap, 16'hFFFE -> 16'h0000) and return to IDLE.
REQ-022 Enqueued data SHALL appear at the head no earlier than the next cycle; there is no bypass from mem_rdata to instr.
REQ-023 valid = (count != 0); the head dequeues when valid=1 and stall=0.
REQ-024 Enqueue and dequeue in the same cycle SHALL both occur, leaving count unchanged.
REQ-025 Issue SHALL require a free slot, so the queue never overflows. An attempted enqueue while full sets err and drops the data.
REQ-026 redirect=1 flushes the queue in that cycle (count=0, valid=0 next cycle) and loads fetch_pc = redirect_pc.
REQ-027 Dequeue in a redirect cycle is ignored.
REQ-028 redirect in REQ without mem_ready -> DROP.
REQ-029 redirect in REQ with mem_ready=1 -> the returning data is discarded and the next state is IDLE.
REQ-030 DROP discards the returning data and goes to IDLE on mem_ready.
REQ-031 A second redirect in DROP overwrites fetch_pc and stays in DROP.
REQ-032 halt=1 -> HALTED after any outstanding request completes; its data is discarded.
REQ-033 In HALTED: no requests, redirect ignored, queue flushed, valid=0; exit only by reset.
REQ-034 halt and redirect in the same cycle: halt wins.
REQ-035 mem_ready=1 with mem_err=1 sets err; the word is not enqueued and the FSM goes to HALTED.
REQ-036 mem_ready=1 while in IDLE or HALTED sets err.

Reset
REQ-037 Asserting rst=0 SHALL immediately force state=IDLE, fetch_pc=RESET_PC, count=0, head/tail=0, mem_req=0, mem_addr=RESET_PC, valid=0, instr=0, pc_inc2=0, err=0.
REQ-038 Reset mid-request abandons the request; the memory model must tolerate mem_req dropping.
REQ-039 The first request SHALL be issued in the second cycle after reset deassertion.

Structure
REQ-040 FSM state encoding, the instruction width of 16, and the HALT opcode constant SHALL live in the shared processor package.
REQ-041 The queue storage SHALL be one sub-module, fetch_fifo: DEPTH entries x 32 bits, pointer wrap at DEPTH, with full/empty flags and a simultaneous push/pop path.
REQ-042 fetch_queue SHALL replace the PC register and fetch logic inside the IF stage. The IF stage consumes instr, pc_inc2 and valid, and drives stall, redirect and halt from the downstream stages.

Verification
REQ-043 Reset release, mem_ready one cycle after every request, stall=0 -> mem_addr sequence 0000, 0002, 0004; valid first high on the cycle after the first mem_ready; pc_inc2 = 0002, 0004, 0006.
REQ-044 stall=1 held for 10 cycles -> exactly 2 entries queued, mem_req low afterwards, head instr unchanged; stall released -> entries drain in order and fetching resumes.
REQ-045 redirect to 16'h0040 while in REQ, with mem_ready 3 cycles later -> the returned word is dropped, the next mem_addr is 0040, and no stale instruction becomes valid.
REQ-046 fetch_pc=16'hFFFE with a successful fetch -> pc_inc2=0000 and the next mem_addr=0000.
REQ-047 mem_ready with mem_err=1 -> err=1 the next cycle and stays 1, state HALTED, mem_req=0; a subsequent redirect has no effect.
REQ-048 rst asserted while mem_req=1 -> all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared processor definitions for the fetch front end:
// instruction width, HALT opcode, fetch FSM states and queue entry layout.
package fetch_queue_pkg;

    localparam int ILEN = 16;

    localparam logic [ILEN-1:0] HALT_OP = 16'hF000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fq_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc_inc2;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: DEPTH x 32-bit ring buffer.
// Flush beats push/pop; push into a full queue is accepted only alongside a pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  fq_entry_t wdata,
    input  logic      pop,
    output fq_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[head];

    // Storage array; contents are don't-care until count says otherwise.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[tail] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: PC register, single-outstanding memory request FSM
// and a small instruction queue feeding decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = 16'h0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [ILEN-1:0] redirect_pc,
    input  logic            halt,
    input  logic            mem_ready,
    input  logic [ILEN-1:0] mem_rdata,
    input  logic            mem_err,
    output logic            mem_req,
    output logic [ILEN-1:0] mem_addr,
    output logic [ILEN-1:0] instr,
    output logic [ILEN-1:0] pc_inc2,
    output logic            valid,
    output logic            err
);

    fq_state_t       state;
    fq_state_t       state_n;
    logic [ILEN-1:0] fetch_pc;
    logic [ILEN-1:0] fetch_pc_n;
    logic [ILEN-1:0] pc_next;
    logic            halt_pend;
    logic            halt_pend_n;
    logic            err_set;
    logic            redir;
    logic            push;
    logic            flush;
    logic            full;
    logic            empty;
    fq_entry_t       wdata;
    fq_entry_t       head;

    assign pc_next = fetch_pc + ILEN'(2);
    assign redir   = redirect && !halt && !halt_pend;
    assign wdata   = '{instr: mem_rdata, pc_inc2: pc_next};
    assign mem_req = (state == REQ) || (state == DROP);
    assign valid   = !empty;
    assign instr   = valid ? head.instr : '0;
    assign pc_inc2 = valid ? head.pc_inc2 : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (wdata),
        .pop   (!stall),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Next-state logic: issue, completion, redirect/halt handling, queue control.
    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        halt_pend_n = halt_pend;
        err_set     = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_ready) err_set = 1'b1;
                if (halt) begin
                    state_n = HALTED;
                end else if (redir) begin
                    fetch_pc_n = redirect_pc;
                    flush      = 1'b1;
                end else if (!full) begin
                    state_n = REQ;
                end
            end
            REQ, DROP: begin
                if (halt) halt_pend_n = 1'b1;
                if (redir) begin
                    fetch_pc_n = redirect_pc;
                    flush      = 1'b1;
                end
                if (mem_ready) begin
                    halt_pend_n = 1'b0;
                    if (mem_err) begin
                        err_set = 1'b1;
                        state_n = HALTED;
                    end else if (halt || halt_pend) begin
                        state_n = HALTED;
                    end else begin
                        state_n = IDLE;
                        if (state == REQ && !redir) begin
                            if (full && stall) begin
                                err_set = 1'b1;
                            end else begin
                                push       = 1'b1;
                                fetch_pc_n = pc_next;
                            end
                        end
                    end
                end else if (redir || halt) begin
                    state_n = DROP;
                end
            end
            HALTED: begin
                if (mem_ready) err_set = 1'b1;
            end
        endcase
        if (state_n == HALTED) flush = 1'b1;
    end

    // State, PC, latched request address and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            mem_addr  <= RESET_PC;
            halt_pend <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            halt_pend <= halt_pend_n;
            err       <= err | err_set;
            if (state == IDLE && state_n == REQ) begin
                mem_addr <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: instruction-stream scoreboard with a
// latency-randomised memory, plus directed reset/redirect/halt/error steps.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] instr;
    logic [15:0] pc_inc2;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    logic [15:0] req_log[$];
    logic [15:0] deq_log[$];
    bit          busy, live, halted, hpend, merr;
    bit          new_req, inject_err, force_ready;
    logic [15:0] cur_addr, nxt_fetch, cap;
    int          lat, lat_fixed, cyc, first_ready, first_valid;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .instr       (instr),
        .pc_inc2     (pc_inc2),
        .valid       (valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, check, drive inputs, advance the model.
    task automatic step(input bit s, input bit r, input logic [15:0] rp,
                        input bit h);
        logic [15:0] hp;
        bit rdy, reff, deq, go_halt;
        @(negedge clk);
        cyc++;
        new_req = 0;
        check("valid", 32'(valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            hp = q[0] + 16'd2;
            check("pc_inc2", 32'(pc_inc2), 32'(hp));
            check("instr", 32'(instr), 32'(word_at(q[0])));
        end
        check("err", 32'(err), 32'(merr));
        if (halted) check("halted_req", 32'(mem_req), 32'(0));
        if (valid && first_valid < 0) first_valid = cyc;
        if (busy) begin
            check("req_hold", 32'(mem_req), 32'(1));
            check("addr_hold", 32'(mem_addr), 32'(cur_addr));
        end else if (mem_req) begin
            new_req = 1;
            check("req_addr", 32'(mem_addr), 32'(nxt_fetch));
            busy = 1;
            live = 1;
            cur_addr = mem_addr;
            lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            req_log.push_back(mem_addr);
        end
        rdy = 0;
        if (busy) begin
            if (lat == 0) rdy = 1;
            else lat--;
        end
        if (force_ready) rdy = 1;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        halt        = h;
        mem_ready   = rdy;
        mem_err     = rdy && busy && inject_err;
        mem_rdata   = (rdy && busy) ? word_at(cur_addr) : 16'($urandom);
        if (rdy && busy && first_ready < 0) first_ready = cyc;
        reff = r && !h && !halted && !hpend;
        deq = (q.size() != 0) && !s && !reff;
        go_halt = 0;
        if (rdy && !busy) merr = 1;
        if (deq) begin
            hp = q[0] + 16'd2;
            deq_log.push_back(hp);
            void'(q.pop_front());
        end
        if (rdy && busy) begin
            busy = 0;
            if (mem_err) begin
                merr = 1;
                go_halt = 1;
            end else if (h || hpend) begin
                go_halt = 1;
            end else if (live && !reff) begin
                q.push_back(cur_addr);
                nxt_fetch = cur_addr + 16'd2;
            end
        end else if (h && !halted) begin
            if (busy) hpend = 1;
            else go_halt = 1;
        end
        if (reff) begin
            q.delete();
            nxt_fetch = rp;
            live = 0;
        end
        if (go_halt) begin
            halted = 1;
            hpend = 0;
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(16'h0000));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_instr", 32'(instr), 32'(0));
        check("rst_pc_inc2", 32'(pc_inc2), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        {stall, redirect, halt, mem_ready, mem_err} = '0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        req_log.delete();
        deq_log.delete();
        {busy, live, halted, hpend, merr, inject_err, force_ready} = '0;
        nxt_fetch = 16'h0000;
        lat = 0;
        cyc = 0;
        first_ready = -1;
        first_valid = -1;
    endtask

    task automatic wait_req(input bit s, input string tag);
        for (int i = 0; i < 40 && !new_req; i++) step(s, 0, 16'h0, 0);
        check(tag, 32'(new_req), 32'(1));
    endtask

    initial begin
        lat_fixed = 1;
        #1;
        do_reset();

        // Sequential fetch, one-cycle memory latency.
        step(0, 0, 16'h0, 0);
        check("first_req", 32'(mem_req), 32'(1));
        repeat (14) step(0, 0, 16'h0, 0);
        check("seq_nreq", 32'(req_log.size() >= 3), 32'(1));
        check("seq_ndeq", 32'(deq_log.size() >= 3), 32'(1));
        check("seq_addr0", 32'(req_log[0]), 32'(16'h0000));
        check("seq_addr1", 32'(req_log[1]), 32'(16'h0002));
        check("seq_addr2", 32'(req_log[2]), 32'(16'h0004));
        check("seq_pc0", 32'(deq_log[0]), 32'(16'h0002));
        check("seq_pc1", 32'(deq_log[1]), 32'(16'h0004));
        check("seq_pc2", 32'(deq_log[2]), 32'(16'h0006));
        check("first_valid", 32'(first_valid), 32'(first_ready + 1));

        // Stall backpressure fills the queue, then drains in order.
        lat_fixed = 0;
        for (int i = 0; i < 11; i++) begin
            step(1, 0, 16'h0, 0);
            if (i == 5) cap = instr;
        end
        check("stall_req", 32'(mem_req), 32'(0));
        check("stall_valid", 32'(valid), 32'(1));
        check("stall_head", 32'(instr), 32'(cap));
        lat_fixed = 3;
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        check("drain_second", 32'(valid), 32'(1));
        step(0, 0, 16'h0, 0);
        check("drain_empty", 32'(valid), 32'(0));
        repeat (6) step(0, 0, 16'h0, 0);

        // Redirect while a request is pending; its data must be dropped.
        lat_fixed = 4;
        new_req = 0;
        wait_req(0, "redir_wait");
        step(0, 1, 16'h0040, 0);
        lat_fixed = 1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 0);
            check("redir_stale", 32'(valid), 32'(0));
        end
        wait_req(0, "redir_wait2");
        check("redir_addr", 32'(mem_addr), 32'(16'h0040));
        repeat (4) step(0, 0, 16'h0, 0);

        // Address wrap at the top of memory.
        step(1, 1, 16'hFFFE, 0);
        new_req = 0;
        wait_req(1, "wrap_wait");
        check("wrap_addr", 32'(mem_addr), 32'(16'hFFFE));
        for (int i = 0; i < 20 && !valid; i++) step(1, 0, 16'h0, 0);
        check("wrap_pc_inc2", 32'(pc_inc2), 32'(16'h0000));
        new_req = 0;
        wait_req(1, "wrap_wait2");
        check("wrap_next", 32'(mem_addr), 32'(16'h0000));

        // Halt with a request outstanding, then a stray mem_ready.
        lat_fixed = 3;
        new_req = 0;
        wait_req(0, "halt_wait");
        step(0, 0, 16'h0, 1);
        repeat (8) step(0, 0, 16'h0, 0);
        check("halt_req", 32'(mem_req), 32'(0));
        check("halt_valid", 32'(valid), 32'(0));
        check("halt_err", 32'(err), 32'(0));
        force_ready = 1;
        step(0, 0, 16'h0, 0);
        force_ready = 0;
        step(0, 0, 16'h0, 0);
        check("stray_ready_err", 32'(err), 32'(1));
        do_reset();

        // Memory fault halts fetch; redirect afterwards is ignored.
        lat_fixed = 1;
        inject_err = 1;
        wait_req(0, "fault_wait");
        step(0, 0, 16'h0, 0);
        inject_err = 0;
        step(0, 0, 16'h0, 0);
        check("fault_err", 32'(err), 32'(1));
        check("fault_req", 32'(mem_req), 32'(0));
        check("fault_valid", 32'(valid), 32'(0));
        step(0, 1, 16'h0100, 0);
        repeat (5) step(0, 0, 16'h0, 0);
        check("fault_redir_req", 32'(mem_req), 32'(0));
        check("fault_sticky", 32'(err), 32'(1));
        check("fault_redir_valid", 32'(valid), 32'(0));
        do_reset();

        // Asynchronous reset in the middle of a request.
        lat_fixed = 3;
        wait_req(0, "arst_wait");
        check("arst_pre_req", 32'(mem_req), 32'(1));
        #2;
        do_reset();

        // Randomised traffic against the stream model.
        lat_fixed = -1;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 16'($urandom) & 16'hFFFE, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
